btn_event_decoder: RTL and testbench
====================================

BTN_EVENT_DECODER -- requirements
Module: btn_event_decoder

Interface
REQ-001 Parameter CLKIN_FREQ, default 27000000, input clock frequency in Hz.
REQ-002 Parameter LONG_PRESS_PERIOD, default 0.5, hold time in seconds before longPress.
REQ-003 Parameter REPEAT_PERIOD, default 0.1, auto-repeat interval in seconds after longPress.
REQ-004 Parameter ACTIVE_LOW, default 1, 1 = btnIn low means pressed.
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 btnIn  input  1  debounced button level, already synchronous to clk.
REQ-008 pressPulse  output  1  one-cycle strobe on press.
REQ-009 releasePulse  output  1  one-cycle strobe on release.
REQ-010 longPress  output  1  one-cycle strobe when the hold reaches LONG_COUNT.
REQ-011 repeatPulse  output  1  one-cycle auto-repeat strobe while held past long press.
REQ-012 held  output  1  level, high while the FSM is not IDLE.

Function
REQ-013 LONG_COUNT = round(CLKIN_FREQ*LONG_PRESS_PERIOD), REPEAT_COUNT = round(CLKIN_FREQ*REPEAT_PERIOD), both evaluated at elaboration, both >= 2.
REQ-014 Counter width = $clog2(max(LONG_COUNT,REPEAT_COUNT)+1); the counter never exceeds max-1.
REQ-015 Pressed = btnIn XOR ACTIVE_LOW; the previous sample is registered as btn_q.
REQ-016 Press edge = pressed & ~btn_q; release edge = ~pressed & btn_q.
REQ-017 All outputs are registered, with no combinational path from btnIn to any output.
REQ-018 FSM states: IDLE, HOLD, REPEAT.
REQ-019 IDLE on press edge -> HOLD: pressPulse=1 for the next cycle, counter cleared.
REQ-020 In HOLD the counter increments each cycle.
REQ-021 In HOLD, when counter = LONG_COUNT-1 with no release edge -> REPEAT: longPress=1, counter cleared.
REQ-022 longPress rises exactly LONG_COUNT cycles after pressPulse rises.
REQ-023 In REPEAT the counter increments each cycle.
REQ-024 In REPEAT, at counter = REPEAT_COUNT-1: repeatPulse=1, counter wraps to 0.
REQ-025 The first repeatPulse follows longPress by REPEAT_COUNT cycles, then repeats every REPEAT_COUNT cycles.
REQ-026 A release edge in HOLD or REPEAT -> IDLE: releasePulse=1, counter cleared.
REQ-027 A release edge has priority over a simultaneous long or repeat threshold: that longPress/repeatPulse is suppressed.
REQ-028 A press edge in the cycle after returning to IDLE is accepted normally, with no dead time.
REQ-029 A press edge while not in IDLE cannot occur; if btn_q is corrupted, the FSM ignores it.
REQ-030 held=1 in HOLD and REPEAT, 0 in IDLE; held updates on the same edge as pressPulse/releasePulse.
REQ-031 At most one of pressPulse, releasePulse, longPress, repeatPulse is high in any cycle.

Reset
REQ-032 reset low asynchronously forces IDLE, counter=0, and all outputs=0.
REQ-033 reset low also sets btn_q to the released level, so a button held through reset yields a pressPulse on the first cycle after reset deasserts.
REQ-034 reset asserted mid-hold discards the hold with no releasePulse.

Structure
REQ-035 The default CLKIN_FREQ (27000000) lives in the shared board constants header, used also by btn_debouncer.
REQ-036 State encodings are local to this module.
REQ-037 There is no sub-module: edge detect, FSM and counter are one module.
REQ-038 btn_event_decoder is instantiated downstream of btn_debouncer, with debounceOut driving btnIn.

Verification
Bench parameters for all scenarios: CLKIN_FREQ=1000, LONG_PRESS_PERIOD=0.010 (LONG_COUNT=10), REPEAT_PERIOD=0.004 (REPEAT_COUNT=4), ACTIVE_LOW=1.
REQ-039 Short tap: btnIn low for 5 cycles -> one pressPulse; releasePulse 5 cycles later; no longPress; held high for 5 cycles.
REQ-040 Long hold: btnIn low for 30 cycles -> pressPulse at t, longPress at t+10, repeatPulse at t+14, t+18, t+22, t+26, t+30 is suppressed by the release edge, releasePulse at t+30.
REQ-041 Release on threshold: btnIn low for exactly 10 cycles -> releasePulse at t+10 and no longPress.
REQ-042 Back-to-back: release then press on the next cycle -> releasePulse and pressPulse in consecutive cycles, held low for exactly 1 cycle.
REQ-043 Reset mid-hold: reset low at t+12 while held -> all outputs 0 immediately, no releasePulse, counter 0.
REQ-044 Held through reset: btnIn low during reset deassertion -> pressPulse on the first cycle after deassertion.

Source files
------------

// File: rtl/btn_event_decoder_pkg.sv
// Board-level constants and elaboration helpers shared by the button front end
// (btn_debouncer -> btn_event_decoder).
package btn_event_decoder_pkg;

  // Board oscillator frequency in Hz.
  localparam int BOARD_CLKIN_FREQ = 27000000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_event_decoder.sv
// Turns a debounced, clk-synchronous button level into press/release strobes,
// a long-press strobe, auto-repeat strobes and a held level.
module btn_event_decoder
  import btn_event_decoder_pkg::*;
#(
  parameter int  CLKIN_FREQ        = BOARD_CLKIN_FREQ,
  parameter real LONG_PRESS_PERIOD = 0.5,
  parameter real REPEAT_PERIOD     = 0.1,
  parameter bit  ACTIVE_LOW        = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btnIn,
  output logic pressPulse,
  output logic releasePulse,
  output logic longPress,
  output logic repeatPulse,
  output logic held
);

  // int' on a real rounds to nearest, giving round(freq*period).
  localparam int LONG_COUNT   = int'(real'(CLKIN_FREQ) * LONG_PRESS_PERIOD);
  localparam int REPEAT_COUNT = int'(real'(CLKIN_FREQ) * REPEAT_PERIOD);
  localparam int CNT_W        = $clog2(max_int(LONG_COUNT, REPEAT_COUNT) + 1);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_COUNT - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_e;

  state_e           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             btn_q;
  logic             pressed, press_edge, rel_edge;
  logic             press_n, rel_n, long_n, rep_n;

  assign pressed    = btnIn ^ ACTIVE_LOW;
  assign press_edge = pressed & ~btn_q;
  assign rel_edge   = ~pressed & btn_q;

  // Release is tested before the thresholds so it suppresses a coincident
  // longPress/repeatPulse; press edges outside IDLE are simply not looked at.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    press_n = 1'b0;
    rel_n   = 1'b0;
    long_n  = 1'b0;
    rep_n   = 1'b0;
    case (state)
      IDLE: begin
        if (press_edge) begin
          state_n = HOLD;
          cnt_n   = '0;
          press_n = 1'b1;
        end
      end
      HOLD: begin
        if (rel_edge) begin
          state_n = IDLE;
          cnt_n   = '0;
          rel_n   = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_n = REPEAT;
          cnt_n   = '0;
          long_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      REPEAT: begin
        if (rel_edge) begin
          state_n = IDLE;
          cnt_n   = '0;
          rel_n   = 1'b1;
        end else if (cnt == REPEAT_LAST) begin
          cnt_n = '0;
          rep_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // btn_q resets to "released" so a button held through reset is seen as a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      btn_q        <= 1'b0;
      pressPulse   <= 1'b0;
      releasePulse <= 1'b0;
      longPress    <= 1'b0;
      repeatPulse  <= 1'b0;
      held         <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      btn_q        <= pressed;
      pressPulse   <= press_n;
      releasePulse <= rel_n;
      longPress    <= long_n;
      repeatPulse  <= rep_n;
      held         <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_btn_event_decoder.sv
// Directed bench for btn_event_decoder with LONG_COUNT=10, REPEAT_COUNT=4.
module tb_btn_event_decoder;

  logic clk = 1'b0;
  logic reset;
  logic btnIn;
  logic pressPulse, releasePulse, longPress, repeatPulse, held;

  btn_event_decoder #(
    .CLKIN_FREQ       (1000),
    .LONG_PRESS_PERIOD(0.010),
    .REPEAT_PERIOD    (0.004),
    .ACTIVE_LOW       (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btnIn       (btnIn),
    .pressPulse  (pressPulse),
    .releasePulse(releasePulse),
    .longPress   (longPress),
    .repeatPulse (repeatPulse),
    .held        (held)
  );

  always #5 clk = ~clk;

  // Output word order: {press, release, long, repeat, held}
  typedef struct {
    logic       btn;
    logic [4:0] exp;
  } vec_t;

  int errors = 0;
  int checks = 0;

  function automatic logic [4:0] outs();
    return {pressPulse, releasePulse, longPress, repeatPulse, held};
  endfunction

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (press,release,long,repeat,held)", name, act, exp);
    end
  endtask

  // Drive btnIn away from the edge, then sample #1 after the rising edge.
  task automatic step(input logic b);
    @(negedge clk);
    btnIn = b;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[11];

  initial begin
    logic [4:0] e;

    // Short tap (5 cycles low), back-to-back re-press, one-cycle tap.
    tbl[0]  = '{1'b1, 5'b00000};
    tbl[1]  = '{1'b0, 5'b10001};
    tbl[2]  = '{1'b0, 5'b00001};
    tbl[3]  = '{1'b0, 5'b00001};
    tbl[4]  = '{1'b0, 5'b00001};
    tbl[5]  = '{1'b0, 5'b00001};
    tbl[6]  = '{1'b1, 5'b01000};
    tbl[7]  = '{1'b0, 5'b10001};
    tbl[8]  = '{1'b1, 5'b01000};
    tbl[9]  = '{1'b1, 5'b00000};
    tbl[10] = '{1'b1, 5'b00000};

    btnIn = 1'b1;
    reset = 1'b0;
    #12;
    chk("reset_state", outs(), 5'b00000);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].btn);
      chk($sformatf("table[%0d]", i), outs(), tbl[i].exp);
    end

    // Long hold: 30 cycles low; the t+30 repeat coincides with release.
    for (int k = 0; k <= 31; k++) begin
      step((k >= 30) ? 1'b1 : 1'b0);
      e = '0;
      e[4] = (k == 0);
      e[3] = (k == 30);
      e[2] = (k == 10);
      e[1] = (k > 10) && (k < 30) && ((k - 10) % 4 == 0);
      e[0] = (k < 30);
      chk($sformatf("long_hold t+%0d", k), outs(), e);
    end

    // Release exactly on the long threshold: no longPress.
    for (int k = 0; k <= 11; k++) begin
      step((k >= 10) ? 1'b1 : 1'b0);
      e = '0;
      e[4] = (k == 0);
      e[3] = (k == 10);
      e[0] = (k < 10);
      chk($sformatf("rel_on_thresh t+%0d", k), outs(), e);
    end

    // Reset mid-hold at t+12 (already in REPEAT), button kept pressed.
    step(1'b0);
    chk("mid_hold press", outs(), 5'b10001);
    for (int k = 1; k <= 11; k++) step(1'b0);
    chk("mid_hold t+11 long seen", outs(), 5'b00001);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_hold async reset", outs(), 5'b00000);
    checks++;
    if (dut.cnt !== '0) begin
      errors++;
      $display("FAIL mid_hold counter: got %0d expected 0", dut.cnt);
    end
    @(posedge clk);
    #1;
    chk("mid_hold in reset", outs(), 5'b00000);

    // Held through reset: pressPulse on the first edge after deassertion.
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("held_through_reset", outs(), 5'b10001);
    step(1'b0);
    chk("held_through_reset t+1", outs(), 5'b00001);
    step(1'b1);
    chk("held_through_reset release", outs(), 5'b01000);
    step(1'b1);
    chk("final idle", outs(), 5'b00000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
